// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one line-wide memory port between an instruction cache (read-only
// line fills) and a data cache (line fills and writebacks). Only one
// transaction is in flight at a time. When both caches ask in the same
// IDLE cycle, the one that was not served last wins. After reset the
// last-served register points at the instruction cache, so the data cache
// wins the first tie.
//
// When a request is granted, the arbiter latches its address, write data and
// direction. The pmem_* address, data and strobe outputs come only from
// those latched values. A requester may therefore drop or change its request
// mid-transaction without disturbing the memory side.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   i_read, i_address      instruction-cache fill request and line address
//   i_resp, i_rdata        completion pulse / fill data to instruction cache
//   d_read, d_write        data-cache fill / writeback request
//   d_address, d_wdata     data-cache line address and writeback data
//   d_resp, d_rdata        completion pulse / fill data to data cache
//   pmem_read, pmem_write  strobes to shared memory (never both)
//   pmem_address           latched line address to shared memory
//   pmem_wdata             latched writeback data to shared memory
//   pmem_rdata, pmem_resp  read data and completion pulse from shared memory
//   busy                   high whenever a transaction is being served
// -----------------------------------------------------------------------------

module mem_arbiter_checker (
    input logic clk,
    input logic reset,
    input logic busy,
    input logic pmem_read,
    input logic pmem_write,
    input logic i_resp,
    input logic d_resp
);

    // The two memory strobes are mutually exclusive
    a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
        !(pmem_read && pmem_write));

    // Exactly one strobe is active while serving, none while idle
    a_busy_strobe: assert property (@(posedge clk) disable iff (reset)
        busy == (pmem_read || pmem_write));

    // At most one requester sees a completion pulse
    a_resp_excl: assert property (@(posedge clk) disable iff (reset)
        !(i_resp && d_resp));

    // No completion pulse can come out of the idle state
    a_idle_no_resp: assert property (@(posedge clk) disable iff (reset)
        !busy |-> !(i_resp || d_resp));

endmodule

module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    // Encoding of the last-served requester
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    last_grant_r;
    logic                    last_grant_next_s;

    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [LINE_WIDTH-1:0]   wdata_r;
    logic                    write_r;
    logic                    write_next_s;

    logic                    busy_r;
    logic                    rd_strobe_r;
    logic                    wr_strobe_r;
    logic                    busy_next_s;
    logic                    rd_next_s;
    logic                    wr_next_s;

    logic                    i_req_s;
    logic                    d_req_s;
    logic                    grant_i_s;
    logic                    grant_d_s;

    // Request decode and grant selection; grants only ever fire in IDLE
    always_comb begin
        i_req_s   = i_read;
        d_req_s   = d_read | d_write;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_r == IDLE) begin
            if (i_req_s && d_req_s) begin
                // Tie: favour whoever was not served last
                if (last_grant_r == GRANT_I) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b1;
                end
            end else if (d_req_s) begin
                grant_d_s = 1'b1;
            end else if (i_req_s) begin
                grant_i_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
                grant_d_s = 1'b0;
            end
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Next-state logic; last_grant moves only when a transaction completes
    always_comb begin
        state_next_s      = state_r;
        last_grant_next_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_next_s = SERVE_D;
                end else if (grant_i_s) begin
                    state_next_s = SERVE_I;
                end else begin
                    // A stray pmem_resp here is deliberately ignored
                    state_next_s = IDLE;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_next_s      = IDLE;
                    last_grant_next_s = GRANT_I;
                end else begin
                    state_next_s = SERVE_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_next_s      = IDLE;
                    last_grant_next_s = GRANT_D;
                end else begin
                    state_next_s = SERVE_D;
                end
            end
            default: begin
                state_next_s      = IDLE;
                last_grant_next_s = GRANT_I;
            end
        endcase
    end

    // Next values of the registered strobes, derived from the next state and direction
    always_comb begin
        write_next_s = write_r;
        if (grant_d_s) begin
            // A simultaneous read and write is treated as a write
            write_next_s = d_write;
        end else if (grant_i_s) begin
            write_next_s = 1'b0;
        end else begin
            write_next_s = write_r;
        end
        busy_next_s = (state_next_s != IDLE);
        rd_next_s   = busy_next_s & ~write_next_s;
        wr_next_s   = busy_next_s &  write_next_s;
    end

    // State, last-grant and registered strobe/busy flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_I;
            write_r      <= 1'b0;
            busy_r       <= 1'b0;
            rd_strobe_r  <= 1'b0;
            wr_strobe_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            last_grant_r <= last_grant_next_s;
            write_r      <= write_next_s;
            busy_r       <= busy_next_s;
            rd_strobe_r  <= rd_next_s;
            wr_strobe_r  <= wr_next_s;
        end
    end

    // Capture address and data of the granted requester at the grant edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= {LINE_WIDTH{1'b0}};
        end else if (grant_d_s) begin
            addr_r  <= d_address;
            wdata_r <= d_wdata;
        end else if (grant_i_s) begin
            // Instruction fills carry no data; clear so stale writeback data does not linger
            addr_r  <= i_address;
            wdata_r <= {LINE_WIDTH{1'b0}};
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Completion pulses must coincide with pmem_resp, so they stay combinational
    always_comb begin
        i_resp = (state_r == SERVE_I) & pmem_resp;
        d_resp = (state_r == SERVE_D) & pmem_resp;
    end

    assign busy         = busy_r;
    assign pmem_read    = rd_strobe_r;
    assign pmem_write   = wr_strobe_r;
    assign pmem_address = addr_r;
    assign pmem_wdata   = wdata_r;
    // Fill data is a straight pass-through; caches qualify it with their resp
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;

    mem_arbiter_checker u_checker (
        .clk        (clk),
        .reset      (reset),
        .busy       (busy_r),
        .pmem_read  (rd_strobe_r),
        .pmem_write (wr_strobe_r),
        .i_resp     (i_resp),
        .d_resp     (d_resp)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. Inputs are driven 1 time unit after
// each rising edge. Outputs are compared near the falling edge against a
// transaction-level reference model. The model holds the transaction in
// flight, the last-served requester and the latched address/data. It advances
// once per clock according to the arbitration rules. Directed scenarios are
// followed by a long randomized run.
// -----------------------------------------------------------------------------

module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          busy;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: transaction in flight and arbitration history
    bit            m_busy;
    bit            m_who;       // 0 = instruction cache, 1 = data cache
    bit            m_write;
    bit            m_last_d;    // last completed transaction was the data cache
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    int            m_serve_cycles;

    // Per-scenario observations
    int            obs_q[$];    // completion order: 0 = I, 1 = D
    int            rd_cnt;
    int            wr_cnt;
    int            iresp_cnt;
    int            dresp_cnt;
    logic [LW-1:0] cap_rdata;

    task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy         = 1'b0;
        m_who          = 1'b0;
        m_write        = 1'b0;
        m_last_d       = 1'b0;
        m_addr         = '0;
        m_wdata        = '0;
        m_serve_cycles = 0;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        rd_cnt    = 0;
        wr_cnt    = 0;
        iresp_cnt = 0;
        dresp_cnt = 0;
        cap_rdata = '0;
    endtask

    function automatic int obs_at(input int k);
        return (k < obs_q.size()) ? obs_q[k] : 9;
    endfunction

    // Outputs that must read zero while reset is held, whatever the inputs do
    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_busy"},   LW'(busy),         '0);
        check_eq({pfx, "_prd"},    LW'(pmem_read),    '0);
        check_eq({pfx, "_pwr"},    LW'(pmem_write),   '0);
        check_eq({pfx, "_paddr"},  LW'(pmem_address), '0);
        check_eq({pfx, "_pwdata"}, pmem_wdata,        '0);
        check_eq({pfx, "_iresp"},  LW'(i_resp),       '0);
        check_eq({pfx, "_dresp"},  LW'(d_resp),       '0);
    endtask

    // One clock: drive, compare against the model, advance the model, move to the next edge
    task automatic step(input bit ir, input logic [AW-1:0] ia,
                        input bit dr, input bit dw, input logic [AW-1:0] da,
                        input logic [LW-1:0] dwd, input bit pr, input logic [LW-1:0] prd);
        bit d_act;
        i_read     = ir;
        i_address  = ia;
        d_read     = dr;
        d_write    = dw;
        d_address  = da;
        d_wdata    = dwd;
        pmem_resp  = pr;
        pmem_rdata = prd;
        #4;
        check_eq("busy",         LW'(busy),         LW'(m_busy));
        check_eq("pmem_read",    LW'(pmem_read),    LW'(m_busy && !m_write));
        check_eq("pmem_write",   LW'(pmem_write),   LW'(m_busy && m_write));
        check_eq("pmem_address", LW'(pmem_address), LW'(m_addr));
        check_eq("pmem_wdata",   pmem_wdata,        m_wdata);
        check_eq("i_resp",       LW'(i_resp),       LW'(m_busy && !m_who && pr));
        check_eq("d_resp",       LW'(d_resp),       LW'(m_busy && m_who && pr));
        check_eq("i_rdata",      i_rdata,           prd);
        check_eq("d_rdata",      d_rdata,           prd);

        rd_cnt += int'(pmem_read);
        wr_cnt += int'(pmem_write);
        if (i_resp) begin
            iresp_cnt++;
            obs_q.push_back(0);
            cap_rdata = i_rdata;
        end
        if (d_resp) begin
            dresp_cnt++;
            obs_q.push_back(1);
            cap_rdata = d_rdata;
        end

        d_act = dr || dw;
        if (m_busy) begin
            if (pr) begin
                m_last_d = m_who;
                m_busy   = 1'b0;
            end else begin
                m_serve_cycles++;
            end
        end else if (ir || d_act) begin
            m_who          = (ir && d_act) ? !m_last_d : d_act;
            m_busy         = 1'b1;
            m_serve_cycles = 1;
            m_write        = m_who && dw;
            m_addr         = m_who ? da : ia;
            m_wdata        = m_who ? dwd : '0;
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [LW-1:0] pat_a5;
        logic [LW-1:0] pat_12;
        pat_a5 = {16{8'hA5}};
        pat_12 = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;

        // Reset with every input active, including a stray pmem_resp
        reset      = 1'b1;
        i_read     = 1'b1;
        i_address  = 16'h1111;
        d_read     = 1'b1;
        d_write    = 1'b1;
        d_address  = 16'h2222;
        d_wdata    = pat_12;
        pmem_resp  = 1'b1;
        pmem_rdata = pat_a5;
        model_reset();
        clear_obs();
        @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        // Both requesters asking in the first cycle out of reset: D first, idle gap, then I
        clear_obs();
        for (int c = 0; c < 10; c++) begin
            bit pr;
            pr = m_busy && (m_serve_cycles == 2);
            step(iresp_cnt == 0, 16'h0100, dresp_cnt == 0, 1'b0, 16'h0200, '0, pr, pat_a5);
        end
        check_eq("tie_first",  LW'(obs_at(0)), LW'(1));
        check_eq("tie_second", LW'(obs_at(1)), LW'(0));
        check_eq("tie_count",  LW'(obs_q.size()), LW'(2));

        // Single instruction fill at 0x1000, three strobe cycles
        clear_obs();
        for (int c = 0; c < 8; c++) begin
            bit pr;
            pr = m_busy && (m_serve_cycles == 3);
            step(c == 0, 16'h1000, 1'b0, 1'b0, 16'h0000, '0, pr, pat_a5);
        end
        check_eq("ifill_rd_cycles", LW'(rd_cnt),    LW'(3));
        check_eq("ifill_wr_cycles", LW'(wr_cnt),    LW'(0));
        check_eq("ifill_iresp",     LW'(iresp_cnt), LW'(1));
        check_eq("ifill_dresp",     LW'(dresp_cnt), LW'(0));
        check_eq("ifill_rdata",     cap_rdata,      pat_a5);

        // Both held for four transactions: strict alternation starting with D
        clear_obs();
        for (int c = 0; c < 24; c++) begin
            bit pr;
            bit rq;
            pr = m_busy && (m_serve_cycles == 2);
            rq = obs_q.size() < 4;
            step(rq, 16'h0A00, rq, 1'b0, 16'h0D00, '0, pr, 128'(c));
        end
        check_eq("alt_n",  LW'(obs_q.size()), LW'(4));
        check_eq("alt_0",  LW'(obs_at(0)), LW'(1));
        check_eq("alt_1",  LW'(obs_at(1)), LW'(0));
        check_eq("alt_2",  LW'(obs_at(2)), LW'(1));
        check_eq("alt_3",  LW'(obs_at(3)), LW'(0));

        // Writeback whose requester changes address and data mid-transaction
        clear_obs();
        for (int c = 0; c < 9; c++) begin
            bit pr;
            pr = m_busy && (m_serve_cycles == 4);
            step(1'b0, 16'h0000, 1'b0, dresp_cnt == 0,
                 (c == 0) ? 16'h2040 : 16'h0000,
                 (c == 0) ? pat_12 : {$urandom(), $urandom(), $urandom(), $urandom()},
                 pr, '0);
        end
        check_eq("wb_wr_cycles", LW'(wr_cnt),    LW'(4));
        check_eq("wb_rd_cycles", LW'(rd_cnt),    LW'(0));
        check_eq("wb_dresp",     LW'(dresp_cnt), LW'(1));

        // Read and write together behave as a write
        clear_obs();
        for (int c = 0; c < 6; c++) begin
            bit pr;
            pr = m_busy && (m_serve_cycles == 2);
            step(1'b0, 16'h0000, c == 0, c == 0, 16'h0300, pat_a5, pr, '0);
        end
        check_eq("rw_rd_cycles", LW'(rd_cnt),    LW'(0));
        check_eq("rw_wr_cycles", LW'(wr_cnt),    LW'(2));
        check_eq("rw_dresp",     LW'(dresp_cnt), LW'(1));

        // Asynchronous reset in the middle of a data fill, then a stray pmem_resp
        clear_obs();
        step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0ABC, '0, 1'b0, '0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0, 1'b0, '0);
        check_eq("arst_pre_busy", LW'(busy),      LW'(1));
        check_eq("arst_pre_prd",  LW'(pmem_read), LW'(1));
        #2;
        reset     = 1'b1;
        pmem_resp = 1'b1;
        #1;
        check_reset_outputs("arst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0, 1'b1, pat_a5);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0, 1'b1, pat_a5);
        check_eq("arst_stray_dresp", LW'(dresp_cnt), LW'(0));

        // Randomized traffic, including stray memory responses while idle
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) < 40, AW'($urandom()),
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20, AW'($urandom()),
                 {$urandom(), $urandom(), $urandom(), $urandom()},
                 $urandom_range(0, 2) == 0,
                 {$urandom(), $urandom(), $urandom(), $urandom()});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
